softmax_seq: RTL

SOFTMAX_SEQ -- requirements
Module: softmax_seq

---
 rtl/softmax_seq_pkg.sv | 17 +
 rtl/softmax_argmax_track.sv | 56 +++++
 rtl/softmax_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/softmax_seq_pkg.sv
// Shared definitions for the softmax classification sequencer.
// Holds the FSM state encoding, the class index width and the default
// class/term counts used by softmax_seq and softmax_argmax_track.
package softmax_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CLS_IDX_W       = 3;
  localparam int DEF_NUM_CLASSES = 6;
  localparam int DEF_TERMS       = 16;

endpackage

// File: rtl/softmax_argmax_track.sv
// Running best-score (and optional best-index) tracker.
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   clear      zero the best registers (start of an inference)
//   update     a class score is being committed this cycle
//   first      the committed score belongs to class 0 (always taken)
//   cand       signed candidate class score
//   cand_idx   class index of the candidate (SOFTMAX_SEQ_ARGMAX_EN only)
//   best_score signed best score so far
//   best_idx   index of the best score (SOFTMAX_SEQ_ARGMAX_EN only)
// Strict greater-than keeps the lowest index on ties.
module softmax_argmax_track
  import softmax_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    update,
  input  logic                    first,
  input  logic signed [WIDTH-1:0] cand,
`ifdef SOFTMAX_SEQ_ARGMAX_EN
  input  logic [CLS_IDX_W-1:0]    cand_idx,
  output logic [CLS_IDX_W-1:0]    best_idx,
`endif
  output logic signed [WIDTH-1:0] best_score
);

  logic take;

  assign take = update && (first || (cand > best_score));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_score <= '0;
    end else if (clear) begin
      best_score <= '0;
    end else if (take) begin
      best_score <= cand;
    end
  end

`ifdef SOFTMAX_SEQ_ARGMAX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_idx <= '0;
    end else if (clear) begin
      best_idx <= '0;
    end else if (take) begin
      best_idx <= cand_idx;
    end
  end
`endif

endmodule

// File: rtl/softmax_seq.sv
// Softmax/argmax classification sequencer.
// Accumulates TERMS PE sums per class for NUM_CLASSES classes, tracks the
// maximum class score and publishes it with a one-cycle done pulse.
// Optional feature macro: SOFTMAX_SEQ_ARGMAX_EN adds class_idx.
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   start           one-cycle request, honoured only in IDLE
//   abort           synchronous cancel; wins over beat/store/done
//   in_valid/in_sum PE sum input; in_ready high in ACCUM
//   softmax_en,busy high while not IDLE
//   accumulate_en   datapath adds in_sum (a beat)
//   store_en        datapath commits its accumulator
//   done            result outputs updated this cycle
//   class_score     best signed score of the last completed inference
//   class_idx       winning class index (macro only)
module softmax_seq
  import softmax_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int TERMS       = DEF_TERMS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_sum,
  output logic                    in_ready,
  output logic                    softmax_en,
  output logic                    accumulate_en,
  output logic                    store_en,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] class_score
`ifdef SOFTMAX_SEQ_ARGMAX_EN
  ,
  output logic [CLS_IDX_W-1:0]    class_idx
`endif
);

  localparam int TERM_W = 16;

  state_t                  state, state_n;
  logic [TERM_W-1:0]       term_cnt;
  logic [CLS_IDX_W-1:0]    cls_cnt;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] best_score;
  logic                    launch;
  logic                    last_term;
  logic                    last_cls;
`ifdef SOFTMAX_SEQ_ARGMAX_EN
  logic [CLS_IDX_W-1:0]    best_idx;
`endif

  assign launch    = (state == IDLE) && start;
  assign last_term = (term_cnt == TERM_W'(TERMS - 1));
  assign last_cls  = (cls_cnt == CLS_IDX_W'(NUM_CLASSES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // abort gates every action output so a cancelled cycle has no side effect.
  always_comb begin
    state_n       = state;
    in_ready      = 1'b0;
    accumulate_en = 1'b0;
    store_en      = 1'b0;
    done          = 1'b0;
    busy          = (state != IDLE);
    softmax_en    = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_n = ACCUM;
      end
      ACCUM: begin
        in_ready      = 1'b1;
        accumulate_en = in_valid && !abort;
        if (in_valid && last_term) state_n = STORE;
      end
      STORE: begin
        store_en = !abort;
        state_n  = last_cls ? DONE : ACCUM;
      end
      DONE: begin
        done    = !abort;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (abort && (state != IDLE)) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_cnt <= '0;
      cls_cnt  <= '0;
      acc      <= '0;
    end else if (launch) begin
      term_cnt <= '0;
      cls_cnt  <= '0;
      acc      <= '0;
    end else if (accumulate_en) begin
      acc      <= acc + in_sum;
      term_cnt <= last_term ? '0 : term_cnt + 1'b1;
    end else if (store_en) begin
      acc     <= '0;
      cls_cnt <= cls_cnt + 1'b1;
    end
  end

  softmax_argmax_track #(
    .WIDTH (WIDTH)
  ) u_track (
    .clk        (clk),
    .rst        (rst),
    .clear      (launch),
    .update     (store_en),
    .first      (cls_cnt == '0),
    .cand       (acc),
`ifdef SOFTMAX_SEQ_ARGMAX_EN
    .cand_idx   (cls_cnt),
    .best_idx   (best_idx),
`endif
    .best_score (best_score)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       class_score <= '0;
    else if (done) class_score <= best_score;
  end

`ifdef SOFTMAX_SEQ_ARGMAX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       class_idx <= '0;
    else if (done) class_idx <= best_idx;
  end
`endif

endmodule
